// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types and helpers for the pipeline trace buffer.
// State and trigger-mode encodings match the values seen on the ports.
package pipe_trace_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TM_IMM = 2'd0,
        TM_PC  = 2'd1,
        TM_OP  = 2'd2,
        TM_EXT = 2'd3
    } trig_mode_e;

    function automatic int entry_w(input int width, input int channels,
                                   input int opw);
        return width + channels * opw;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: one write port, one registered read port.
// Contents are never reset; the read register holds while re is low.
module trace_ram
    import pipe_trace_buffer_pkg::*;
#(
    parameter int DW    = 56,
    parameter int DEPTH = 16,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// On-chip trace buffer: captures PC and stage opcodes around a trigger,
// then streams the frozen window oldest-first over valid/ready.
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OPW       = 6,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    localparam int AW       = clog2(DEPTH),
    localparam int EW       = entry_w(WIDTH, CHANNELS, OPW)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [WIDTH-1:0]        pc_in,
    input  logic [CHANNELS*OPW-1:0] op_in,
    input  logic                    arm,
    input  logic [1:0]              trig_mode,
    input  logic [WIDTH-1:0]        trig_pc,
    input  logic [OPW-1:0]          trig_op,
    input  logic                    trig_ext,
    input  logic                    rd_start,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [EW-1:0]           rd_data,
    output logic                    rd_last,
    output logic [AW-1:0]           trig_idx,
    output logic [AW:0]             fill,
    output logic [2:0]              state
);

    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_INIT = (AW+1)'(POST_TRIG);
    localparam logic [AW:0] ONE_F     = (AW+1)'(1);
    localparam logic [AW:0] TWO_F     = (AW+1)'(2);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [AW-1:0] TWO_A   = AW'(2);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [AW-1:0] trig_idx_q, trig_idx_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW:0]   post_q, post_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic [EW-1:0] rd_data_q, rd_data_d;

    logic          we;
    logic          re;
    logic          hit;
    logic [AW-1:0] raddr;
    logic [AW-1:0] oldest;
    logic [AW:0]   rd_pos;
    logic [EW-1:0] ram_rdata;

    assign oldest = wr_ptr_q - fill_q[AW-1:0];
    assign rd_pos = {1'b0, rd_idx_q};

    always_comb begin
        hit = 1'b0;
        unique case (1'b1)
            trig_mode == TM_IMM: hit = 1'b1;
            trig_mode == TM_PC:  hit = (pc_in == trig_pc);
            trig_mode == TM_OP:  hit = (op_in[OPW-1:0] == trig_op);
            trig_mode == TM_EXT: hit = trig_ext;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        rd_idx_d    = rd_idx_q;
        fill_d      = fill_q;
        post_d      = post_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;
        we          = 1'b0;
        re          = 1'b0;
        raddr       = oldest + rd_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    fill_d   = '0;
                    wr_ptr_d = '0;
                end
            end
            ST_ARMED: begin
                if (sample_en) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_A;
                    if (fill_q != FULL) fill_d = fill_q + ONE_F;
                    if (hit) begin
                        trig_addr_d = wr_ptr_q;
                        if (POST_TRIG == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                            post_d  = POST_INIT;
                        end
                    end
                end
            end
            ST_POST: begin
                if (sample_en) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_A;
                    post_d   = post_q - ONE_F;
                    if (fill_q != FULL) fill_d = fill_q + ONE_F;
                    if (post_q == ONE_F) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rd_start) begin
                    state_d  = ST_READ;
                    re       = 1'b1;
                    raddr    = oldest;
                    rd_idx_d = '0;
                end
            end
            ST_READ: begin
                // RAM output always holds the entry after the one on rd_data
                if (!rd_valid_q) begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_pos + ONE_F == fill_q);
                    re         = 1'b1;
                    raddr      = oldest + rd_idx_q + ONE_A;
                end else if (rd_ready) begin
                    if (rd_last_q) begin
                        state_d    = ST_IDLE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        rd_data_d = ram_rdata;
                        rd_idx_d  = rd_idx_q + ONE_A;
                        rd_last_d = (rd_pos + TWO_F == fill_q);
                        re        = 1'b1;
                        raddr     = oldest + rd_idx_q + TWO_A;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        trig_idx_d = trig_addr_d - (wr_ptr_d - fill_d[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            trig_idx_q  <= '0;
            rd_idx_q    <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            trig_idx_q  <= trig_idx_d;
            rd_idx_q    <= rd_idx_d;
            fill_q      <= fill_d;
            post_q      <= post_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
        end
    end

    trace_ram #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata ({pc_in, op_in}),
        .re    (re),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_last  = rd_last_q;
    assign trig_idx = trig_idx_q;
    assign fill     = fill_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer with DEPTH=8, POST_TRIG=3.
// A capture model fills the expected window; readout pops and compares.
module tb_pipe_trace_buffer;

    localparam int W   = 32;
    localparam int OPW = 6;
    localparam int CH  = 4;
    localparam int D   = 8;
    localparam int PT  = 3;
    localparam int AW  = 3;
    localparam int ENT = W + CH * OPW;

    logic              clk;
    logic              rst;
    logic              sample_en;
    logic [W-1:0]      pc_in;
    logic [CH*OPW-1:0] op_in;
    logic              arm;
    logic [1:0]        trig_mode;
    logic [W-1:0]      trig_pc;
    logic [OPW-1:0]    trig_op;
    logic              trig_ext;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [ENT-1:0]    rd_data;
    logic              rd_last;
    logic [AW-1:0]     trig_idx;
    logic [AW:0]       fill;
    logic [2:0]        state;

    pipe_trace_buffer #(
        .WIDTH     (W),
        .OPW       (OPW),
        .CHANNELS  (CH),
        .DEPTH     (D),
        .POST_TRIG (PT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .pc_in     (pc_in),
        .op_in     (op_in),
        .arm       (arm),
        .trig_mode (trig_mode),
        .trig_pc   (trig_pc),
        .trig_op   (trig_op),
        .trig_ext  (trig_ext),
        .rd_start  (rd_start),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .trig_idx  (trig_idx),
        .fill      (fill),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;
    logic [ENT-1:0] hist[$];
    logic [ENT-1:0] sb[$];
    int  trig_pos;
    int  post_left;
    bit  m_trig;
    bit  m_done;
    int  n_win;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CH*OPW-1:0] mk_op(input logic [W-1:0] pc);
        logic [OPW-1:0] c0;
        c0 = (pc == 4 || pc == 5) ? 6'h23 : pc[OPW-1:0];
        return {pc[5:0] + 6'd3, pc[5:0] + 6'd2, pc[5:0] + 6'd1, c0};
    endfunction

    task automatic step(input bit en, input logic [W-1:0] pc, input bit ext,
                        input logic [1:0] mode, input logic [W-1:0] tpc);
        logic [CH*OPW-1:0] op;
        bit hit;
        op = mk_op(pc);
        sample_en = en;
        pc_in = pc;
        op_in = op;
        trig_ext = ext;
        @(posedge clk);
        if (en && !m_done) begin
            hist.push_back({pc, op});
            if (!m_trig) begin
                case (mode)
                    2'd0: hit = 1'b1;
                    2'd1: hit = (pc == tpc);
                    2'd2: hit = (op[OPW-1:0] == 6'h23);
                    default: hit = ext;
                endcase
                if (hit) begin
                    m_trig = 1'b1;
                    trig_pos = hist.size() - 1;
                    post_left = PT;
                    m_done = (PT == 0);
                end
            end else begin
                post_left--;
                if (post_left == 0) m_done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic capture(input logic [1:0] mode, input logic [W-1:0] tpc,
                           input bit alt, input logic [W-1:0] ext_pc);
        int n;
        int st;
        hist.delete();
        m_trig = 1'b0;
        m_done = 1'b0;
        trig_mode = mode;
        trig_pc = tpc;
        trig_op = 6'h23;
        arm = 1'b1;
        sample_en = 1'b1;
        pc_in = 100;
        op_in = mk_op(100);
        @(posedge clk);
        #1;
        arm = 1'b0;
        for (int c = 0; c < 100 && !m_done; c++)
            step(alt ? c[0] : 1'b1, W'(c), W'(c) == ext_pc, mode, tpc);
        chk("cap_done", m_done, 1);
        n = hist.size() < D ? hist.size() : D;
        st = hist.size() - n;
        @(negedge clk);
        chk("state_done", state, 3);
        chk("fill", fill, n);
        chk("trig_idx", trig_idx, trig_pos - st);
        sb.delete();
        for (int i = st; i < hist.size(); i++) sb.push_back(hist[i]);
        arm = 1'b1;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        sample_en = 1'b0;
        @(negedge clk);
        chk("frozen_state", state, 3);
        chk("frozen_fill", fill, n);
        @(posedge clk);
        #1;
        n_win = n;
    endtask

    task automatic readout(input int n, input int stall_at, input int abort_at);
        int acc;
        int stall;
        int cyc;
        bit first;
        bit done;
        acc = 0;
        stall = 0;
        cyc = 0;
        first = 1'b1;
        done = 1'b0;
        rd_ready = 1'b0;
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        while (cyc < 200 && !done) begin
            if (acc == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk("abort_valid", rd_valid, 0);
                chk("abort_state", state, 0);
                chk("abort_fill", fill, 0);
                @(posedge clk);
                #1;
                rst = 1'b1;
                sb.delete();
                return;
            end
            rd_ready = !(acc == stall_at && stall < 3);
            @(negedge clk);
            if (cyc == 0) chk("rd_state", state, 4);
            if (rd_valid) begin
                if (first) begin
                    first = 1'b0;
                    chk("rd_lat", cyc, 1);
                end
                if (sb.size() == 0) begin
                    chk("rd_extra", rd_valid, 0);
                end else begin
                    chk("rd_data", rd_data, sb[0]);
                    chk("rd_last", rd_last, sb.size() == 1);
                    if (rd_ready) begin
                        void'(sb.pop_front());
                        acc++;
                    end else begin
                        stall++;
                    end
                end
            end else if (acc == n) begin
                chk("end_state", state, 0);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rd_finished", done, 1);
        chk("rd_count", acc, n);
        chk("sb_empty", sb.size(), 0);
        rd_ready = 1'b0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b0;
        sample_en = 1'b0;
        pc_in = '0;
        op_in = '0;
        arm = 1'b0;
        trig_mode = 2'd0;
        trig_pc = '0;
        trig_op = '0;
        trig_ext = 1'b0;
        rd_start = 1'b0;
        rd_ready = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_tidx", trig_idx, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_last", rd_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        trig_mode = 2'd3;
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = W'(i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("armed_state", state, 1);
        chk("armed_fill", fill, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_fill", fill, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("noarm_state", state, 0);
        chk("noarm_fill", fill, 0);
        @(posedge clk);
        #1;
        sample_en = 1'b0;

        capture(2'd0, 32'd0, 1'b0, 32'd1000);
        readout(n_win, -1, -1);

        capture(2'd1, 32'd10, 1'b0, 32'd1000);
        readout(n_win, 2, -1);

        capture(2'd2, 32'd0, 1'b1, 32'd1000);
        readout(n_win, -1, -1);

        capture(2'd3, 32'd0, 1'b0, 32'd2);
        readout(n_win, -1, 2);

        capture(2'd0, 32'd0, 1'b0, 32'd1000);
        readout(n_win, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable on-chip trace buffer for the 5-stage pipelined cpu. It supersedes ad-hoc simulation printouts of PC and per-stage opcodes.
- Each enabled cycle it captures PC plus CHANNELS stage opcodes into a circular buffer of DEPTH entries.
- Capture freezes a programmable number of samples after a trigger (immediate, PC match, opcode match, external).
- The frozen window is then streamed out oldest-first over a valid/ready port. Sits beside the cpu top and taps pc_out and opcode_step_2..5.

Parameters:
WIDTH, 32, PC width
OPW, 6, opcode width per channel
CHANNELS, 4, number of opcode channels (stage 2..5 by default)
DEPTH, 16, buffer entries; power of two, >= 4
POST_TRIG, 8, samples captured after the trigger sample; 0..DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
sample_en  in  1  capture qualifier (pipeline cycle valid)
pc_in  in  WIDTH  PC to trace
op_in  in  CHANNELS*OPW  opcodes; channel 0 in LSBs
arm  in  1  pulse; IDLE->ARMED
trig_mode  in  2  0 immediate, 1 PC match, 2 opcode match ch0, 3 external
trig_pc  in  WIDTH  PC compare value
trig_op  in  OPW  opcode compare value
trig_ext  in  1  external trigger
rd_start  in  1  pulse; DONE->READ
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts
rd_data  out  WIDTH+CHANNELS*OPW  {pc, op_in} of current entry
rd_last  out  1  final entry of window
trig_idx  out  clog2(DEPTH)  readout position of trigger sample
fill  out  clog2(DEPTH)+1  valid entries
state  out  3  0 IDLE, 1 ARMED, 2 POST, 3 DONE, 4 READ

Behaviour:
- Reset (rst=0, async): state=IDLE; rd_valid=0; rd_last=0; rd_data=0; fill=0; trig_idx=0; wr_ptr=0; post counter=0. Memory contents are don't-care.
- IDLE: no writes. arm=1 -> ARMED, clears fill and wr_ptr. arm is ignored in any other state.
- ARMED: each cycle with sample_en=1:
  - write {pc_in, op_in} at wr_ptr; wr_ptr++ mod DEPTH; fill saturates at DEPTH.
  - evaluate the trigger on the same sample:
    - mode 0: first ARMED sample.
    - mode 1: pc_in==trig_pc.
    - mode 2: op_in[OPW-1:0]==trig_op.
    - mode 3: trig_ext=1.
  - on trigger: record trigger address. POST_TRIG=0 -> DONE next cycle; else -> POST with counter=POST_TRIG.
  - sample_en=0 cycles write nothing and never trigger.
- POST: each sample_en=1 cycle writes and decrements the counter. The write that brings the counter to 0 -> DONE. Triggers are ignored.
- DONE: buffer frozen; fill and trig_idx stable. trig_idx = (trigger address - oldest address) mod DEPTH, where oldest = wr_ptr - fill mod DEPTH. If the trigger entry was overwritten (fill=DEPTH and POST_TRIG>=DEPTH is impossible by parameter range), no special case is needed. rd_start -> READ.
- READ:
  - rd_valid=1 with rd_data registered from the oldest entry, one cycle after entering READ; one-cycle read latency from memory is hidden by a 1-entry output register.
  - on rd_valid&&rd_ready: advance to the next entry. rd_data and rd_last hold stable while rd_ready=0.
  - rd_last=1 on entry number fill-1. Acceptance of the last entry -> IDLE, rd_valid=0 the next cycle.
  - arm and rd_start are ignored.
- mode 0 with arm and sample_en in the same cycle: the arm cycle itself is not sampled; the first sample is on the next sample_en cycle.
- Simultaneous trigger and wrap: write and wrap occur normally; the trigger address is the pre-increment wr_ptr.
- Mid-operation reset aborts any state to IDLE immediately; rd_valid drops asynchronously.
- Pointer arithmetic is modulo DEPTH via natural wrap of clog2(DEPTH)-bit counters.

Decomposition:
- Shared package/header: state encodings, trig_mode encodings, entry-width helper (WIDTH+CHANNELS*OPW), clog2 function.
- One natural sub-module: trace_ram, a DEPTH x entry-width simple dual-port RAM (one write port, one registered read port). The FSM, pointers and trigger compare stay in the top.

Test Plan:
- Reset with DEPTH=8, POST_TRIG=3: hold rst=0 mid-stream -> state=0, rd_valid=0, fill=0. Release; no capture until arm.
- Mode 0: arm, then pc=0,1,2,... with sample_en=1 -> DONE after pc=3, fill=4, trig_idx=0. Readout yields pc 0,1,2,3 with rd_last only on pc=3, then state=IDLE.
- Mode 1, trig_pc=10, pc increments from 0 -> wraps; capture ends at pc=13, fill=8. Readout pc 6..13, trig_idx=4.
- Mode 2, trig_op=0x23 on ch0 at pc=5, sample_en low every other cycle -> only enabled samples stored. Window ends at the 3rd enabled sample after the trigger; trig_idx indexes pc=5.
- Backpressure: rd_ready=0 for 3 cycles mid-read -> rd_data/rd_last unchanged, no entry skipped or duplicated. Total entries read equals fill.
- Reset during READ after 2 accepted entries -> rd_valid=0 immediately, state=IDLE. A new arm and capture works normally.
